// File: rtl/lru_fill_responder.sv
// lru_fill_responder: line-fill backend that snapshots a stored line and streams it MSB-first as beats
module lru_fill_responder #(
  parameter int TAGS_WIDTH = 48,
  parameter int CACHE_SIZE = 512,
  parameter int DATA_PORT_SIZE = 512,
  parameter int MEM_DEPTH = 16,
  parameter int LATENCY = 2,
  localparam int IDX_W = $clog2(MEM_DEPTH)
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      req_tvalid,
  output logic                      req_tready,
  input  logic [TAGS_WIDTH-1:0]     req_tdata,
  output logic                      rsp_tvalid,
  input  logic                      rsp_tready,
  output logic [DATA_PORT_SIZE-1:0] rsp_tdata,
  output logic                      rsp_tlast,
  output logic                      rsp_err,
  input  logic                      wr_en,
  input  logic [IDX_W-1:0]          wr_idx,
  input  logic [CACHE_SIZE-1:0]     wr_data,
  output logic [31:0]               req_count
);
  localparam int BEATS = CACHE_SIZE / DATA_PORT_SIZE;
  localparam int BW = $clog2(BEATS + 1);
  localparam int WW = $clog2(LATENCY + 1);
  typedef enum logic [2:0] {IDLE = 3'b001, WAIT = 3'b010, SEND = 3'b100} state_t;
  state_t state, state_d;
  logic [CACHE_SIZE-1:0] mem [MEM_DEPTH];
  logic [CACHE_SIZE-1:0] line_buf;
  logic [WW-1:0] wait_cnt;
  logic [BW-1:0] beat_cnt;
  logic line_err, oor, load;
  assign oor = |req_tdata[TAGS_WIDTH-1:IDX_W];
  assign load = (state == WAIT && wait_cnt == '0) || (state == SEND && rsp_tready && !rsp_tlast);
  always_ff @(posedge clk)
    if (!rstn) state <= IDLE;
    else state <= state_d;
  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (req_tvalid) state_d = WAIT;
      WAIT: if (wait_cnt == '0) state_d = SEND;
      SEND: if (rsp_tready && rsp_tlast) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    req_tready = state[0];
    rsp_tvalid = state[2];
  end
  always_ff @(posedge clk)
    if (rstn && wr_en) mem[wr_idx] <= wr_data;
  always_ff @(posedge clk)
    if (!rstn) begin
      rsp_tdata <= '0;
      rsp_tlast <= 1'b0;
      rsp_err <= 1'b0;
      req_count <= '0;
    end else begin
      if (state == IDLE && req_tvalid) begin
        line_buf <= oor ? '0 : mem[req_tdata[IDX_W-1:0]];
        line_err <= oor;
        wait_cnt <= WW'(LATENCY - 1);
        beat_cnt <= '0;
        req_count <= req_count + 32'd1;
      end
      if (state == WAIT && wait_cnt != '0) wait_cnt <= wait_cnt - WW'(1);
      if (load) begin
        rsp_tdata <= line_buf[CACHE_SIZE-1 -: DATA_PORT_SIZE];
        line_buf <= line_buf << DATA_PORT_SIZE;
        rsp_tlast <= beat_cnt == BW'(BEATS - 1);
        rsp_err <= line_err;
        beat_cnt <= beat_cnt + BW'(1);
      end
    end
endmodule

// File: tb/tb_lru_fill_responder.sv
// tb_lru_fill_responder: table, directed and randomized checks of the line-fill responder
module tb_lru_fill_responder;
  localparam int TW = 16, CS = 128, DP = 32, NB = CS / DP;
  localparam logic [CS-1:0] L3 = 128'h0011_2233_4455_6677_8899_aabb_ccdd_eeff;
  localparam logic [CS-1:0] L15 = 128'hdead_beef_cafe_f00d_0123_4567_89ab_cdef;
  logic clk = 0, rstn = 0;
  always #5 clk = ~clk;
  logic req_tvalid = 0, req_tready, rsp_tvalid, rsp_tready = 0, rsp_tlast, rsp_err, wr_en = 0;
  logic [TW-1:0] req_tdata = '0;
  logic [DP-1:0] rsp_tdata;
  logic [3:0] wr_idx = '0;
  logic [CS-1:0] wr_data = '0;
  logic [31:0] req_count;
  logic b_req_tvalid = 0, b_req_tready, b_rsp_tvalid, b_rsp_tready = 0, b_rsp_tlast, b_rsp_err, b_wr_en = 0;
  logic [7:0] b_req_tdata = '0;
  logic [31:0] b_rsp_tdata, b_wr_data = '0, b_req_count;
  logic [1:0] b_wr_idx = '0;
  int n_chk = 0, n_fail = 0;
  logic [31:0] exp_count = 0;
  logic [CS-1:0] ref_mem [16];
  typedef struct { logic [TW-1:0] tag; logic [7:0] mask; logic err; logic [CS-1:0] line; } vec_t;
  vec_t vt [5];
  lru_fill_responder #(.TAGS_WIDTH(TW), .CACHE_SIZE(CS), .DATA_PORT_SIZE(DP), .MEM_DEPTH(16), .LATENCY(2)) u0 (
    .clk(clk), .rstn(rstn), .req_tvalid(req_tvalid), .req_tready(req_tready), .req_tdata(req_tdata),
    .rsp_tvalid(rsp_tvalid), .rsp_tready(rsp_tready), .rsp_tdata(rsp_tdata), .rsp_tlast(rsp_tlast),
    .rsp_err(rsp_err), .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data), .req_count(req_count));
  lru_fill_responder #(.TAGS_WIDTH(8), .CACHE_SIZE(32), .DATA_PORT_SIZE(32), .MEM_DEPTH(4), .LATENCY(1)) u1 (
    .clk(clk), .rstn(rstn), .req_tvalid(b_req_tvalid), .req_tready(b_req_tready), .req_tdata(b_req_tdata),
    .rsp_tvalid(b_rsp_tvalid), .rsp_tready(b_rsp_tready), .rsp_tdata(b_rsp_tdata), .rsp_tlast(b_rsp_tlast),
    .rsp_err(b_rsp_err), .wr_en(b_wr_en), .wr_idx(b_wr_idx), .wr_data(b_wr_data), .req_count(b_req_count));
  task automatic chk(input string name, input logic [CS-1:0] act, input logic [CS-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [CS-1:0] rnd();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction
  task automatic run_req(input logic [TW-1:0] tag, input logic [7:0] mask, input logic exp_err,
                         input logic [CS-1:0] line, input logic rw, input logic same_wr, input logic [CS-1:0] nd);
    int k = 0, cyc = 0;
    @(negedge clk);
    chk("idle_tready", CS'(req_tready), CS'(1));
    req_tvalid = 1;
    req_tdata = tag;
    if (same_wr) begin
      wr_en = 1;
      wr_idx = tag[3:0];
      wr_data = nd;
    end
    @(posedge clk);
    if (same_wr) ref_mem[tag[3:0]] = nd;
    @(negedge clk);
    req_tvalid = 0;
    wr_en = 0;
    exp_count++;
    chk("accept_tready", CS'(req_tready), '0);
    chk("req_count", CS'(req_count), CS'(exp_count));
    chk("latency_n", CS'(rsp_tvalid), '0);
    @(negedge clk);
    chk("latency_n1", CS'(rsp_tvalid), '0);
    @(negedge clk);
    while (k < NB && cyc < 200) begin
      chk("beat_valid", CS'(rsp_tvalid), CS'(1));
      chk("beat_data", CS'(rsp_tdata), CS'(line[CS-1-k*DP -: DP]));
      chk("beat_last", CS'(rsp_tlast), CS'(k == NB - 1));
      chk("beat_err", CS'(rsp_err), CS'(exp_err));
      chk("busy_tready", CS'(req_tready), '0);
      rsp_tready = mask != 0 ? mask[cyc % 8] : 1'($urandom_range(0, 1));
      req_tvalid = 1'($urandom_range(0, 1));
      req_tdata = 16'($urandom);
      wr_en = rw & 1'($urandom_range(0, 1));
      wr_idx = 4'($urandom);
      wr_data = rnd();
      @(posedge clk);
      if (wr_en) ref_mem[wr_idx] = wr_data;
      if (rsp_tready) k++;
      @(negedge clk);
      cyc++;
    end
    req_tvalid = 0;
    rsp_tready = 0;
    wr_en = 0;
    chk("beats_done", CS'(k), CS'(NB));
    chk("done_valid", CS'(rsp_tvalid), '0);
    chk("done_tready", CS'(req_tready), CS'(1));
    chk("count_stable", CS'(req_count), CS'(exp_count));
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    logic [TW-1:0] tag;
    logic [CS-1:0] nd, line;
    req_tvalid = 1;
    req_tdata = 16'd3;
    repeat (3) @(posedge clk);
    @(negedge clk);
    req_tvalid = 0;
    rstn = 1;
    chk("rst_tready", CS'(req_tready), CS'(1));
    chk("rst_valid", CS'(rsp_tvalid), '0);
    chk("rst_last", CS'(rsp_tlast), '0);
    chk("rst_err", CS'(rsp_err), '0);
    chk("rst_data", CS'(rsp_tdata), '0);
    chk("rst_count", CS'(req_count), '0);
    chk("rst_b_count", CS'(b_req_count), '0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      wr_en = 1;
      wr_idx = 4'(i);
      wr_data = i == 3 ? L3 : i == 15 ? L15 : rnd();
      @(posedge clk);
      ref_mem[i] = wr_data;
    end
    @(negedge clk);
    wr_en = 0;
    vt[0] = '{16'd3, 8'hFF, 1'b0, L3};
    vt[1] = '{16'h0010, 8'hFF, 1'b1, '0};
    vt[2] = '{16'd15, 8'b1001_1001, 1'b0, L15};
    vt[3] = '{16'h8003, 8'h55, 1'b1, '0};
    vt[4] = '{16'd15, 8'h00, 1'b0, L15};
    for (int i = 0; i < 5; i++) run_req(vt[i].tag, vt[i].mask, vt[i].err, vt[i].line, 1'b0, 1'b0, '0);
    nd = rnd();
    run_req(16'd5, 8'hFF, 1'b0, ref_mem[5], 1'b0, 1'b1, nd);
    run_req(16'd5, 8'hFF, 1'b0, nd, 1'b0, 1'b0, '0);
    repeat (20) begin
      tag = $urandom_range(0, 3) == 0 ? 16'($urandom) | 16'h0100 : 16'($urandom_range(0, 15));
      run_req(tag, 8'h00, |tag[15:4], |tag[15:4] ? '0 : ref_mem[tag[3:0]], 1'b1, 1'b0, '0);
    end
    line = ref_mem[7];
    @(negedge clk);
    req_tvalid = 1;
    req_tdata = 16'd7;
    @(posedge clk);
    @(negedge clk);
    req_tvalid = 0;
    repeat (2) @(negedge clk);
    chk("rst_mid_beat0", CS'(rsp_tdata), CS'(line[CS-1 -: DP]));
    rsp_tready = 1;
    @(negedge clk);
    chk("rst_mid_beat1", CS'(rsp_tdata), CS'(line[CS-1-DP -: DP]));
    rsp_tready = 0;
    rstn = 0;
    @(negedge clk);
    rstn = 1;
    exp_count = 0;
    chk("rst_mid_valid", CS'(rsp_tvalid), '0);
    chk("rst_mid_tready", CS'(req_tready), CS'(1));
    chk("rst_mid_count", CS'(req_count), '0);
    chk("rst_mid_data", CS'(rsp_tdata), '0);
    @(negedge clk);
    chk("rst_mid_no_beat", CS'(rsp_tvalid), '0);
    run_req(16'd7, 8'hFF, 1'b0, ref_mem[7], 1'b0, 1'b0, '0);
    @(negedge clk);
    b_wr_en = 1;
    b_wr_idx = 2'd1;
    b_wr_data = 32'hA5A5_0001;
    @(negedge clk);
    b_wr_idx = 2'd2;
    b_wr_data = 32'h5A5A_0002;
    @(negedge clk);
    b_wr_en = 0;
    b_req_tvalid = 1;
    b_req_tdata = 8'd1;
    b_rsp_tready = 1;
    @(negedge clk);
    b_req_tdata = 8'd2;
    chk("b2b_accept_tready", CS'(b_req_tready), '0);
    chk("b2b_lat_valid", CS'(b_rsp_tvalid), '0);
    chk("b2b_count1", CS'(b_req_count), CS'(1));
    @(negedge clk);
    chk("b2b_beat1_valid", CS'(b_rsp_tvalid), CS'(1));
    chk("b2b_beat1_data", CS'(b_rsp_tdata), CS'(32'hA5A5_0001));
    chk("b2b_beat1_last", CS'(b_rsp_tlast), CS'(1));
    chk("b2b_beat1_err", CS'(b_rsp_err), '0);
    @(negedge clk);
    chk("b2b_gap_valid", CS'(b_rsp_tvalid), '0);
    chk("b2b_gap_tready", CS'(b_req_tready), CS'(1));
    @(negedge clk);
    b_req_tvalid = 0;
    chk("b2b_second_tready", CS'(b_req_tready), '0);
    chk("b2b_count2", CS'(b_req_count), CS'(2));
    @(negedge clk);
    chk("b2b_beat2_valid", CS'(b_rsp_tvalid), CS'(1));
    chk("b2b_beat2_data", CS'(b_rsp_tdata), CS'(32'h5A5A_0002));
    chk("b2b_beat2_last", CS'(b_rsp_tlast), CS'(1));
    @(negedge clk);
    b_rsp_tready = 0;
    chk("b2b_end_valid", CS'(b_rsp_tvalid), '0);
    chk("b2b_end_tready", CS'(b_req_tready), CS'(1));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
